dac_update_scheduler: RTL

Sample-rate scheduler that sits between the calibrated-word path (per-channel DAC words) and the SPI serializer for the dual-channel 12-bit DAC. It buffers A/B sample pairs in a small FIFO and fires one update per programmable sample tick. On each update it sequences channel A, then channel B, through the serializer's start/busy/done handshake, then pulses LDAC so both outputs change together. It flags underruns (tick with no data) and late ticks (tick while an update is still in flight).

---
 rtl/dac_update_scheduler.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/dac_update_scheduler.sv
// dac_update_scheduler
// Paces A/B sample pairs from a small FIFO to the DAC SPI serializer.
// Each programmable sample tick sends channel A, then channel B, through the
// serializer start/busy/done handshake. It then pulses LDAC low so both DAC
// outputs change together. Ticks that find the FIFO empty raise an underrun
// pulse. Ticks that arrive while an update is still running raise a late_tick
// pulse and are dropped.
module dac_update_scheduler #(
   parameter int         FIFO_DEPTH      = 4,
   parameter int         RATE_W          = 16,
   parameter int         LDAC_LOW_CYCLES = 2,
   parameter logic [2:0] CFG_BITS        = 3'b011,
   localparam int        LVL_W           = $clog2(FIFO_DEPTH + 1)
) (
   input  logic              clk100,
   input  logic              rst,
   input  logic              enable,
   input  logic [RATE_W-1:0] rate_div,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [11:0]       s_data_a,
   input  logic [11:0]       s_data_b,
   output logic              spi_start,
   output logic [15:0]       spi_word,
   input  logic              spi_busy,
   input  logic              spi_done,
   output logic              ldac,
   output logic              underrun,
   output logic              late_tick,
   output logic [15:0]       underrun_count,
   output logic [LVL_W-1:0]  fifo_level
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LAT_W = (LDAC_LOW_CYCLES > 1) ? $clog2(LDAC_LOW_CYCLES) : 1;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_START_A = 3'd1;
   localparam logic [2:0] ST_WAIT_A  = 3'd2;
   localparam logic [2:0] ST_START_B = 3'd3;
   localparam logic [2:0] ST_WAIT_B  = 3'd4;
   localparam logic [2:0] ST_LATCH   = 3'd5;

   logic [RATE_W-1:0] cnt_r;
   logic [RATE_W-1:0] rate_lat_r;
   logic              tick_r;

   logic [23:0]       mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [LVL_W-1:0]  level_r;
   logic              push_s;
   logic              pop_s;
   logic              s_ready_s;
   logic [11:0]       head_a_s;
   logic [11:0]       head_b_s;

   logic [2:0]        state_r;
   logic [11:0]       hold_a_r;
   logic [11:0]       hold_b_r;
   logic              spi_start_r;
   logic [15:0]       spi_word_r;
   logic              ldac_r;
   logic              underrun_r;
   logic              late_tick_r;
   logic [15:0]       underrun_count_r;
   logic [LAT_W-1:0]  lat_cnt_r;

   // s_ready depends only on the level register, so a pop cannot reach it combinationally.
   assign s_ready_s = (level_r != LVL_W'(FIFO_DEPTH));
   assign push_s    = s_valid && s_ready_s;
   assign pop_s     = tick_r && (state_r == ST_IDLE) && (level_r != {LVL_W{1'b0}});
   assign head_a_s  = mem_r[rd_ptr_r][23:12];
   assign head_b_s  = mem_r[rd_ptr_r][11:0];

   // Tick generator: the counter runs 0..rate_div, with one registered tick per wrap; rate_div is re-sampled at each wrap.
   always_ff @(posedge clk100) begin
      if (rst) begin
         cnt_r      <= {RATE_W{1'b0}};
         rate_lat_r <= {RATE_W{1'b0}};
         tick_r     <= 1'b0;
      end else if (!enable) begin
         cnt_r      <= {RATE_W{1'b0}};
         rate_lat_r <= rate_div;
         tick_r     <= 1'b0;
      end else if (cnt_r >= rate_lat_r) begin
         cnt_r      <= {RATE_W{1'b0}};
         rate_lat_r <= rate_div;
         tick_r     <= 1'b1;
      end else begin
         cnt_r      <= cnt_r + RATE_W'(1);
         tick_r     <= 1'b0;
      end
   end

   // FIFO storage: no reset is needed because the pointers and level decide which entries are valid.
   always_ff @(posedge clk100) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= {s_data_a, s_data_b};
      end
   end

   // FIFO pointers and occupancy; a push and a pop in the same cycle leave the level unchanged.
   always_ff @(posedge clk100) begin
      if (rst) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         level_r  <= {LVL_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push_s, pop_s})
            2'b10:   level_r <= level_r + LVL_W'(1);
            2'b01:   level_r <= level_r - LVL_W'(1);
            default: level_r <= level_r;
         endcase
      end
   end

   // Update sequencer: starts channel A, then channel B, then drives the LDAC strobe; it also flags underrun and late ticks.
   always_ff @(posedge clk100) begin
      if (rst) begin
         state_r          <= ST_IDLE;
         hold_a_r         <= 12'h000;
         hold_b_r         <= 12'h000;
         spi_start_r      <= 1'b0;
         spi_word_r       <= 16'h0000;
         ldac_r           <= 1'b1;
         underrun_r       <= 1'b0;
         late_tick_r      <= 1'b0;
         underrun_count_r <= 16'h0000;
         lat_cnt_r        <= {LAT_W{1'b0}};
      end else begin
         spi_start_r <= 1'b0;
         underrun_r  <= 1'b0;
         late_tick_r <= tick_r && (state_r != ST_IDLE);
         case (state_r)
            ST_IDLE: begin
               if (tick_r) begin
                  if (level_r != {LVL_W{1'b0}}) begin
                     hold_a_r <= head_a_s;
                     hold_b_r <= head_b_s;
                     // If the serializer is already idle, start channel A now to save a cycle.
                     if (!spi_busy) begin
                        spi_start_r <= 1'b1;
                        spi_word_r  <= {1'b0, CFG_BITS, head_a_s};
                        state_r     <= ST_WAIT_A;
                     end else begin
                        state_r     <= ST_START_A;
                     end
                  end else begin
                     underrun_r <= 1'b1;
                     if (underrun_count_r != 16'hFFFF) begin
                        underrun_count_r <= underrun_count_r + 16'd1;
                     end
                  end
               end
            end
            ST_START_A: begin
               if (!spi_busy) begin
                  spi_start_r <= 1'b1;
                  spi_word_r  <= {1'b0, CFG_BITS, hold_a_r};
                  state_r     <= ST_WAIT_A;
               end
            end
            ST_WAIT_A: begin
               if (spi_done) begin
                  state_r <= ST_START_B;
               end
            end
            ST_START_B: begin
               if (!spi_busy) begin
                  spi_start_r <= 1'b1;
                  spi_word_r  <= {1'b1, CFG_BITS, hold_b_r};
                  state_r     <= ST_WAIT_B;
               end
            end
            ST_WAIT_B: begin
               if (spi_done) begin
                  ldac_r    <= 1'b0;
                  lat_cnt_r <= {LAT_W{1'b0}};
                  state_r   <= ST_LATCH;
               end
            end
            ST_LATCH: begin
               if (lat_cnt_r == LAT_W'(LDAC_LOW_CYCLES - 1)) begin
                  ldac_r  <= 1'b1;
                  state_r <= ST_IDLE;
               end else begin
                  lat_cnt_r <= lat_cnt_r + LAT_W'(1);
               end
            end
            default: begin
               ldac_r  <= 1'b1;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign s_ready        = s_ready_s;
   assign spi_start      = spi_start_r;
   assign spi_word       = spi_word_r;
   assign ldac           = ldac_r;
   assign underrun       = underrun_r;
   assign late_tick      = late_tick_r;
   assign underrun_count = underrun_count_r;
   assign fifo_level     = level_r;

endmodule
